// File: rtl/alu_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md_pkg : opcodes, multiply/divide state encoding and helpers      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alu_md_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_LUI   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_MULT  = 4'd8;
  localparam logic [3:0] ALU_MULTU = 4'd9;
  localparam logic [3:0] ALU_DIV   = 4'd10;
  localparam logic [3:0] ALU_DIVU  = 4'd11;
  localparam logic [3:0] ALU_MFHI  = 4'd12;
  localparam logic [3:0] ALU_MFLO  = 4'd13;
  localparam logic [3:0] ALU_MTHI  = 4'd14;
  localparam logic [3:0] ALU_MTLO  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= ALU_MULT) && (op <= ALU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_iter : iterative unsigned shift-add multiply / restoring divide   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_fix,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int              CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_acc, r_mq, r_opnd;
  logic             r_div;
  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH-1:0] w_diff, w_acc_nxt, w_mq_nxt;

  // r_acc holds the running high half (mult) or partial remainder (div);
  // r_mq shifts out multiplier bits or shifts in quotient bits.
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_opnd : '0)};
    w_shift = {r_acc, r_mq[WIDTH-1]};
    w_diff  = w_shift[WIDTH-1:0] - r_opnd;
    if (r_div) begin
      if (w_shift >= {1'b0, r_opnd}) begin
        w_acc_nxt = w_diff;
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[WIDTH-1:0];
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_count == C_LAST) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && i_start) begin
        r_count <= '0;
        r_acc   <= '0;
        r_mq    <= i_a;
        r_opnd  <= i_b;
        r_div   <= i_div;
      end else if (r_state == ST_RUN) begin
        r_acc   <= w_acc_nxt;
        r_mq    <= w_mq_nxt;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_fix  = (r_state == ST_FIX);
  assign o_hi   = r_acc;
  assign o_lo   = r_mq;

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md : EX-stage ALU with iterative multiply/divide and HI/LO       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             oflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int HALF = WIDTH / 2;

  logic [3:0]         w_op;
  logic [WIDTH-1:0]   w_sum, w_diff, w_a_mag, w_b_mag, w_it_hi, w_it_lo;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_busy, w_fix, w_md_acc, w_mt_acc, w_signed, w_neg_a, w_neg_b, w_is_div;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_mult, r_neg_q, r_neg_r, r_divz;

  assign w_op  = aluop[3:0];
  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    out   = '0;
    oflow = 1'b0;
    case (w_op)
      ALU_ADD: begin
        out   = w_sum;
        oflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        out   = w_diff;
        oflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_OR:   out = a | b;
      ALU_AND:  out = a & b;
      ALU_XOR:  out = a ^ b;
      ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_LUI:  out = {b[HALF-1:0], {HALF{1'b0}}};
      ALU_MFHI: out = r_hi;
      ALU_MFLO: out = r_lo;
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);

  // Operands enter the iterator as magnitudes; signs are remembered here
  // and reapplied in the FIX cycle.
  assign w_md_acc = start && !w_busy && is_md_op(w_op);
  assign w_mt_acc = start && !w_busy && ((w_op == ALU_MTHI) || (w_op == ALU_MTLO));
  assign w_signed = (w_op == ALU_MULT) || (w_op == ALU_DIV);
  assign w_is_div = (w_op == ALU_DIV) || (w_op == ALU_DIVU);
  assign w_neg_a  = w_signed && a[WIDTH-1];
  assign w_neg_b  = w_signed && b[WIDTH-1];
  assign w_a_mag  = w_neg_a ? (~a + 1'b1) : a;
  assign w_b_mag  = w_neg_b ? (~b + 1'b1) : b;

  md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_acc),
    .i_div   (w_is_div),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_busy  (w_busy),
    .o_fix   (w_fix),
    .o_hi    (w_it_hi),
    .o_lo    (w_it_lo)
  );

  assign w_prod = r_neg_q ? (~{w_it_hi, w_it_lo} + 1'b1) : {w_it_hi, w_it_lo};

  always_comb begin
    if (r_mult) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else begin
      w_res_hi = r_neg_r ? (~w_it_hi + 1'b1) : w_it_hi;
      // Divide by zero returns an all-ones quotient regardless of signs.
      w_res_lo = r_divz ? '1 : (r_neg_q ? (~w_it_lo + 1'b1) : w_it_lo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_mult  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_md_acc) begin
        r_mult  <= !w_is_div;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        r_divz  <= w_is_div && (b == '0);
      end
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_acc) begin
        if (w_op == ALU_MTHI) r_hi <= a;
        else                  r_lo <= a;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_md : randomized + directed bench with a behavioural model     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alu_md;
  import alu_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  aluop = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        start = 1'b0;
  logic [31:0] out, hi, lo;
  logic        zero, oflow, busy, done;

  logic [3:0]  op16 = 4'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        st16 = 1'b0;
  logic [15:0] out16, hi16, lo16;
  logic        zero16, oflow16, busy16, done16;

  alu_md #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .a(a), .b(b), .start(start),
    .out(out), .zero(zero), .oflow(oflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_md #(.WIDTH(16), .OP_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .aluop(op16), .a(a16), .b(b16), .start(st16),
    .out(out16), .zero(zero16), .oflow(oflow16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] e_out;
  logic        e_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    logic [63:0] t, h;
    h = 64'd1 << (w - 1);
    t = 64'(v) & ((64'd1 << w) - 64'd1);
    return longint'(t ^ h) - longint'(h);
  endfunction

  // Architectural mult/div result for a w-bit datapath.
  function automatic void md_ref(input int w, input logic [3:0] op, input logic [31:0] ua,
                                 input logic [31:0] ub, output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] mask, p, xa, xb;
    longint      sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    xa = 64'(ua) & mask;
    xb = 64'(ub) & mask;
    sa = sx(ua, w);
    sb = sx(ub, w);
    rh = '0;
    rl = '0;
    if (op == ALU_MULT || op == ALU_MULTU) begin
      p  = (op == ALU_MULT) ? 64'(sa * sb) : xa * xb;
      rh = 32'((p >> w) & mask);
      rl = 32'(p & mask);
    end else if (xb == 64'd0) begin
      rh = 32'(xa);
      rl = 32'(mask);
    end else if (op == ALU_DIV) begin
      q  = sa / sb;
      r  = sa % sb;
      rh = 32'(64'(r) & mask);
      rl = 32'(64'(q) & mask);
    end else begin
      rh = 32'(xa % xb);
      rl = 32'(xa / xb);
    end
  endfunction

  function automatic void comb_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] h, input logic [31:0] l,
                                   output logic [31:0] o, output logic ov);
    longint s;
    o  = '0;
    ov = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        s  = (op == ALU_ADD) ? longint'($signed(x)) + longint'($signed(y))
                             : longint'($signed(x)) - longint'($signed(y));
        o  = 32'(s);
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_OR:   o = x | y;
      ALU_AND:  o = x & y;
      ALU_XOR:  o = x ^ y;
      ALU_SLT:  o = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLTU: o = (x < y) ? 32'd1 : 32'd0;
      ALU_LUI:  o = y << 16;
      ALU_MFHI: o = h;
      ALU_MFLO: o = l;
      default:  o = '0;
    endcase
  endfunction

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit busy_pre;
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      busy_pre = (m_cnt != 0);
      m_done = 1'b0;
      if (busy_pre) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end
      if (start && !busy_pre) begin
        if (aluop >= ALU_MULT && aluop <= ALU_DIVU) begin
          md_ref(32, aluop, a, b, p_hi, p_lo);
          m_cnt = 33;
        end else if (aluop == ALU_MTHI) m_hi = a;
        else if (aluop == ALU_MTLO) m_lo = a;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      comb_ref(aluop, a, b, m_hi, m_lo, e_out, e_ov);
      chk("out", out, e_out);
      chk("zero", zero, (e_out == 32'd0));
      chk("oflow", oflow, e_ov);
      chk("busy", busy, (m_cnt != 0));
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic s);
    aluop = op; a = x; b = y; start = s;
  endtask

  task automatic comb_dir(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eo, input logic eov);
    logic [31:0] mo;
    logic        mov;
    drive(op, x, y, 1'b0);
    #1;
    chk({name, "_out"}, out, eo);
    chk({name, "_oflow"}, oflow, eov);
    chk({name, "_zero"}, zero, (eo == 32'd0));
    comb_ref(op, x, y, m_hi, m_lo, mo, mov);
    chk({name, "_model"}, {mo, 31'd0, mov}, {eo, 31'd0, eov});
    tick();
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int drop_at);
    logic [31:0] old_hi, mh, ml;
    int          n;
    md_ref(32, op, x, y, mh, ml);
    chk({name, "_model"}, {mh, ml}, {eh, el});
    old_hi = m_hi;
    drive(op, x, y, 1'b1);
    tick();
    drive(ALU_MFHI, 32'h5, 32'h9, 1'b0);
    #1;
    chk({name, "_mfhi_busy"}, out, old_hi);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      if (n == drop_at) drive(ALU_MULT, 32'd100, 32'd100, 1'b1);
      else              drive(ALU_MFHI, 32'h5, 32'h9, 1'b0);
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 33);
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  task automatic run16(input string name, input logic [3:0] op, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] eh, input logic [15:0] el);
    logic [31:0] mh, ml;
    int          n;
    md_ref(16, op, {16'd0, x}, {16'd0, y}, mh, ml);
    chk({name, "_model16"}, {mh, ml}, {16'd0, eh, 16'd0, el});
    op16 = op; a16 = x; b16 = y; st16 = 1'b1;
    tick();
    st16 = 1'b0; op16 = ALU_ADD;
    n = 0;
    while (busy16 === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_latency16"}, n, 17);
    chk({name, "_done16"}, done16, 1'b1);
    chk({name, "_hi16"}, hi16, eh);
    chk({name, "_lo16"}, lo16, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    model_clear();
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_hilo16", {hi16, lo16, 1'b0, busy16}, 34'd0);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    comb_dir("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    comb_dir("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    comb_dir("add_zero", ALU_ADD, 32'h5, 32'hFFFF_FFFB, 32'h0, 1'b0);
    comb_dir("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    comb_dir("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    comb_dir("lui", ALU_LUI, 32'h0, 32'h0000_1234, 32'h1234_0000, 1'b0);
    comb_dir("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    comb_dir("xor", ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    comb_dir("or", ALU_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);

    // Back-to-back: each run starts in the previous run's done cycle.
    run_md("mult", ALU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    run_md("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, -1);
    run_md("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 7);
    run_md("divu0", ALU_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, -1);
    run_md("divmin", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1);
    tick();

    drive(ALU_MTHI, 32'hCAFE_0001, 32'd0, 1'b1); tick();
    drive(ALU_MTLO, 32'h0BAD_F00D, 32'd0, 1'b1); tick();
    chk("mthi_nobusy", busy, 1'b0);
    drive(ALU_MFHI, 32'd0, 32'd0, 1'b0); #1; chk("mfhi_rt", out, 32'hCAFE_0001);
    drive(ALU_MFLO, 32'd0, 32'd0, 1'b0); #1; chk("mflo_rt", out, 32'h0BAD_F00D);
    tick();

    drive(ALU_MULT, 32'h0012_3456, 32'd789, 1'b1); tick();
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    repeat (10) tick();
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    tick();
    rst_n = 1'b1;
    run_md("mult67", ALU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    repeat (700) begin
      drive(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 3) == 0));
      tick();
    end
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    n = 0;
    while (m_cnt != 0 && n < 50) begin tick(); n++; end
    tick();

    run16("m16", ALU_MULT, 16'hFFFD, 16'd5, 16'hFFFF, 16'hFFF1);
    run16("mu16", ALU_MULTU, 16'hFFFF, 16'd2, 16'h1, 16'hFFFE);
    run16("d16", ALU_DIV, 16'hFFF9, 16'd2, 16'hFFFF, 16'hFFFD);
    run16("du16", ALU_DIVU, 16'd7, 16'd0, 16'd7, 16'hFFFF);
    run16("dmin16", ALU_DIV, 16'h8000, 16'hFFFF, 16'h0, 16'h8000);
    tick();
    op16 = ALU_MTHI; a16 = 16'h1234; st16 = 1'b1; tick();
    op16 = ALU_MTLO; a16 = 16'h5678; tick();
    st16 = 1'b0;
    op16 = ALU_MFHI; #1; chk("mfhi16_rt", out16, 16'h1234);
    op16 = ALU_MFLO; #1; chk("mflo16_rt", out16, 16'h5678);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
